// File: rtl/ser_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ser_tx_ctrl : 8b/10b link transmit controller (training burst, data, comma).|
// | Optional disparity check: define SER_TX_CTRL_RD_CHECK_EN.                   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module ser_tx_ctrl #(
   parameter int TRAIN_LEN    = 16,
   parameter int COMMA_PERIOD = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              train_req,
   output logic [7:0]        ser_data,
   output logic              ser_k,
   output logic signed [1:0] ser_rd,
   input  logic signed [1:0] ser_rd_next,
   output logic              link_up,
   output logic              rd_err
);

   localparam int TRAIN_CHARS = 2 * TRAIN_LEN;
   localparam int TW = (TRAIN_CHARS > 1) ? $clog2(TRAIN_CHARS) : 1;
   localparam int CW = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
   localparam logic [7:0]    K28_5      = 8'hBC;
   localparam logic [7:0]    D21_5      = 8'hB5;
   localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CHARS - 1);
   localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_PERIOD - 1);

   typedef enum logic [0:0] {
      TRAIN = 1'b0,
      DATA  = 1'b1
   } state_t;

   state_t        state;
   logic [TW-1:0] train_cnt;
   logic [CW-1:0] comma_cnt;
   logic          comma_due;
   logic          accept;

   assign comma_due = (comma_cnt == COMMA_LAST);
   assign s_ready   = (state == DATA) && !train_req && !comma_due;
   assign accept    = s_valid && s_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= TRAIN;
         train_cnt <= '0;
         comma_cnt <= '0;
         ser_data  <= K28_5;
         ser_k     <= 1'b1;
         ser_rd    <= -2'sd1;
         link_up   <= 1'b0;
      end else begin
         ser_rd <= ser_rd_next;
         // A training request behaves like a synchronous return to the reset image.
         if (train_req) begin
            state     <= TRAIN;
            train_cnt <= '0;
            comma_cnt <= '0;
            ser_data  <= K28_5;
            ser_k     <= 1'b1;
            link_up   <= 1'b0;
         end else if (state == TRAIN) begin
            comma_cnt <= '0;
            ser_data  <= train_cnt[0] ? D21_5 : K28_5;
            ser_k     <= ~train_cnt[0];
            if (train_cnt == TRAIN_LAST) begin
               state     <= DATA;
               link_up   <= 1'b1;
               train_cnt <= '0;
            end else begin
               train_cnt <= train_cnt + TW'(1);
            end
         end else begin
            // comma_due blocks accept, so the increment never passes COMMA_LAST.
            if (accept) begin
               ser_data  <= s_data;
               ser_k     <= 1'b0;
               comma_cnt <= comma_cnt + CW'(1);
            end else begin
               ser_data  <= K28_5;
               ser_k     <= 1'b1;
               comma_cnt <= '0;
            end
         end
      end
   end

`ifdef SER_TX_CTRL_RD_CHECK_EN
   logic rd_bad;
   assign rd_bad = (ser_rd_next != 2'sb01) && (ser_rd_next != 2'sb11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_err <= 1'b0;
      end else begin
         rd_err <= (rd_err && !train_req) || rd_bad;
      end
   end
`else
   assign rd_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ser_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ser_tx_ctrl : directed vector bench for ser_tx_ctrl (TRAIN_LEN=4, CP=8). |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_ser_tx_ctrl;

   localparam logic [1:0] RM = 2'b11;
   localparam logic [1:0] RP = 2'b01;
   localparam logic [7:0] BC = 8'hBC;
   localparam logic [7:0] B5 = 8'hB5;
`ifdef SER_TX_CTRL_RD_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              train_req;
   logic [7:0]        ser_data;
   logic              ser_k;
   logic signed [1:0] ser_rd;
   logic signed [1:0] ser_rd_next;
   logic              link_up;
   logic              rd_err;

   int checks = 0;
   int errors = 0;

   ser_tx_ctrl #(.TRAIN_LEN(4), .COMMA_PERIOD(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .train_req   (train_req),
      .ser_data    (ser_data),
      .ser_k       (ser_k),
      .ser_rd      (ser_rd),
      .ser_rd_next (ser_rd_next),
      .link_up     (link_up),
      .rd_err      (rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       v;
      logic       tr;
      logic [1:0] rdn;
      logic       rdy;
      logic [7:0] data;
      logic       k;
      logic [1:0] rd;
      logic       link;
   } vec_t;

   vec_t vecs[64];
   int   nv = 0;

   task automatic add(input logic [7:0] d, input logic v, input logic tr, input logic [1:0] rdn,
                      input logic rdy, input logic [7:0] data, input logic k,
                      input logic [1:0] rd, input logic link);
      vecs[nv] = '{d, v, tr, rdn, rdy, data, k, rd, link};
      nv++;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge: drive, check s_ready, clock once, check registered outputs.
   task automatic step(input string nm, input logic [7:0] d, input logic v, input logic tr,
                       input logic [1:0] rdn, input logic rdy, input logic [7:0] data,
                       input logic k, input logic [1:0] rd, input logic link);
      s_data      = d;
      s_valid     = v;
      train_req   = tr;
      ser_rd_next = rdn;
      #1;
      chk({nm, " s_ready"}, {7'b0, s_ready}, {7'b0, rdy});
      @(posedge clk);
      #1;
      chk({nm, " ser_data"}, ser_data, data);
      chk({nm, " ser_k"}, {7'b0, ser_k}, {7'b0, k});
      chk({nm, " ser_rd"}, {6'b0, $unsigned(ser_rd)}, {6'b0, rd});
      chk({nm, " link_up"}, {7'b0, link_up}, {7'b0, link});
      @(negedge clk);
   endtask

   initial begin
      // Reset release and training burst; bytes offered during training must be ignored.
      for (int i = 0; i < 8; i++)
         add(8'hEE, 1'b1, 1'b0, RM, 1'b0, (i % 2 == 0) ? BC : B5, (i % 2 == 0), RM, (i == 7));
      for (int i = 1; i <= 7; i++)
         add(8'(i), 1'b1, 1'b0, RM, 1'b1, 8'(i), 1'b0, RM, 1'b1);
      add(8'h08, 1'b1, 1'b0, RM, 1'b0, BC,    1'b1, RM, 1'b1);
      add(8'h08, 1'b1, 1'b0, RM, 1'b1, 8'h08, 1'b0, RM, 1'b1);
      add(8'h09, 1'b0, 1'b0, RM, 1'b1, BC,    1'b1, RM, 1'b1);
      add(8'hA5, 1'b1, 1'b1, RM, 1'b0, BC,    1'b1, RM, 1'b0);
      for (int i = 0; i < 8; i++)
         add(8'hA5, 1'b1, 1'b0, RM, 1'b0, (i % 2 == 0) ? BC : B5, (i % 2 == 0), RM, (i == 7));
      add(8'hA5, 1'b1, 1'b0, RP, 1'b1, 8'hA5, 1'b0, RP, 1'b1);
      add(8'h00, 1'b0, 1'b0, RM, 1'b1, BC,    1'b1, RM, 1'b1);
      add(8'h00, 1'b0, 1'b0, RP, 1'b1, BC,    1'b1, RP, 1'b1);

      rst_n       = 1'b0;
      s_data      = 8'h55;
      s_valid     = 1'b1;
      train_req   = 1'b0;
      ser_rd_next = RP;
      repeat (2) @(negedge clk);
      chk("reset ser_data", ser_data, BC);
      chk("reset ser_k", {7'b0, ser_k}, 8'h01);
      chk("reset ser_rd", {6'b0, $unsigned(ser_rd)}, {6'b0, RM});
      chk("reset link_up", {7'b0, link_up}, 8'h00);
      chk("reset rd_err", {7'b0, rd_err}, 8'h00);
      chk("reset s_ready", {7'b0, s_ready}, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < nv; i++)
         step($sformatf("v%0d", i), vecs[i].d, vecs[i].v, vecs[i].tr, vecs[i].rdn,
              vecs[i].rdy, vecs[i].data, vecs[i].k, vecs[i].rd, vecs[i].link);

      // Training request in DATA, then a restart in the middle of the new burst.
      step("treq_data", 8'h00, 1'b0, 1'b1, RM, 1'b0, BC, 1'b1, RM, 1'b0);
      for (int i = 0; i < 3; i++)
         step($sformatf("part%0d", i), 8'h00, 1'b0, 1'b0, RM, 1'b0,
              (i % 2 == 0) ? BC : B5, (i % 2 == 0), RM, 1'b0);
      step("treq_train", 8'h00, 1'b0, 1'b1, RM, 1'b0, BC, 1'b1, RM, 1'b0);
      for (int i = 0; i < 8; i++)
         step($sformatf("restart%0d", i), 8'h00, 1'b0, 1'b0, RM, 1'b0,
              (i % 2 == 0) ? BC : B5, (i % 2 == 0), RM, (i == 7));

      // Illegal disparity sets the sticky flag (when built in); train_req clears it.
      step("rd_zero", 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, BC, 1'b1, 2'b00, 1'b1);
      chk("rd_err set", {7'b0, rd_err}, {7'b0, EXP_ERR});
      step("rd_hold", 8'h3C, 1'b1, 1'b0, RM, 1'b1, 8'h3C, 1'b0, RM, 1'b1);
      chk("rd_err sticky", {7'b0, rd_err}, {7'b0, EXP_ERR});
      step("rd_clr", 8'h00, 1'b0, 1'b1, RM, 1'b0, BC, 1'b1, RM, 1'b0);
      chk("rd_err cleared", {7'b0, rd_err}, 8'h00);

      // Asynchronous reset in the middle of a burst, away from any clock edge.
      step("pre_rst0", 8'h00, 1'b0, 1'b0, RP, 1'b0, BC, 1'b1, RP, 1'b0);
      step("pre_rst1", 8'h00, 1'b0, 1'b0, RP, 1'b0, B5, 1'b0, RP, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async ser_data", ser_data, BC);
      chk("async ser_k", {7'b0, ser_k}, 8'h01);
      chk("async ser_rd", {6'b0, $unsigned(ser_rd)}, {6'b0, RM});
      chk("async link_up", {7'b0, link_up}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst0", 8'h00, 1'b1, 1'b0, RM, 1'b0, BC, 1'b1, RM, 1'b0);
      step("post_rst1", 8'h00, 1'b1, 1'b0, RM, 1'b0, B5, 1'b0, RM, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
